// File: rtl/segment_transition_ctl_pkg.sv
// -----------------------------------------------------------------------------
// segment_transition_ctl_pkg
//   Shared types and constants for the segment transition controller:
//   transition-mode encoding, controller state encoding and the
//   infinite-repeat value.
// -----------------------------------------------------------------------------
package segment_transition_ctl_pkg;

  // Transition-mode encoding as written by the controller register file.
  typedef enum logic [7:0] {
    MODE_SYNC_IDX = 8'h00,
    MODE_SYS_TIME = 8'h01,
    MODE_GPIO     = 8'h02,
    MODE_EXT      = 8'hF0
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_TRIG,
    ST_PLAY_FINITE,
    ST_EXT
  } state_e;

  // Infinite-repeat value: all-ones in the low `width` bits (width <= 64).
  // The caller casts the result down to its own repeat-count width.
  function automatic logic [63:0] rep_infinite(int width);
    return (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
  endfunction

endpackage

// File: rtl/segment_transition_ctl_trigger_detect.sv
// -----------------------------------------------------------------------------
// segment_transition_ctl_trigger_detect
//   Decodes the requested transition mode, holds the mode/operand of the
//   pending request, and raises a single-cycle trig while armed and the
//   pending condition is met.
//
//   Optional feature macro: SEGMENT_TRANSITION_GPIO_EN builds GPIO mode
//   (pin edge detector and pin select). Without it GPIO mode decodes as
//   unknown and gpio is ignored.
//
// Ports:
//   CLK, RST   clock, synchronous active-high reset
//   req_mode   mode field of the incoming request (decoded combinationally)
//   req_value  operand of the incoming request
//   load       accept the incoming request as the new pending request
//   sys_time   free-running system time
//   gpio       synchronised trigger pins
//   loop_end   sampler index wrap pulse
//   arm        controller is waiting for a trigger
//   req_ext    incoming request uses EXT mode
//   req_wait   incoming request uses a trigger-waiting mode
//   trig       pending condition met (single cycle, only while armed)
// -----------------------------------------------------------------------------
module segment_transition_ctl_trigger_detect
  import segment_transition_ctl_pkg::*;
#(
  parameter int TIME_W = 64,
  parameter int GPIO_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [7:0]        req_mode,
  input  logic [TIME_W-1:0] req_value,
  input  logic              load,
  input  logic [TIME_W-1:0] sys_time,
  input  logic [GPIO_W-1:0] gpio,
  input  logic              loop_end,
  input  logic              arm,
  output logic              req_ext,
  output logic              req_wait,
  output logic              trig
);

  mode_e             mode_q;
  logic [TIME_W-1:0] value_q;
  logic              cmp_q;
  logic              cond;

  // NOTE: every output of an always_comb gets a default before any branch;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    req_ext  = (req_mode == MODE_EXT);
    req_wait = (req_mode == MODE_SYNC_IDX) || (req_mode == MODE_SYS_TIME);
`ifdef SEGMENT_TRANSITION_GPIO_EN
    req_wait = req_wait || (req_mode == MODE_GPIO);
`endif
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mode_q  <= MODE_SYNC_IDX;
      value_q <= '0;
      cmp_q   <= 1'b0;
    end else begin
      if (load) begin
        mode_q  <= mode_e'(req_mode);
        value_q <= req_value;
      end
      // Cleared on load so a result against the previous operand can never
      // fire the new request; the first real compare lands one cycle later.
      cmp_q <= load ? 1'b0 : (sys_time >= value_q);
    end
  end

`ifdef SEGMENT_TRANSITION_GPIO_EN
  logic [GPIO_W-1:0] gpio_q;
  logic [3:0]        rise;
  logic              edge_q;

  // Zero-padded to 4 so the 2-bit pin select never indexes out of range.
  assign rise = 4'(gpio & ~gpio_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      gpio_q <= '0;
      edge_q <= 1'b0;
    end else begin
      gpio_q <= gpio;
      edge_q <= load ? 1'b0 : rise[value_q[1:0]];
    end
  end
`else
  logic unused_gpio;
  assign unused_gpio = ^gpio;
`endif

  always_comb begin
    cond = 1'b0;
    case (mode_q)
      MODE_SYNC_IDX: cond = loop_end;
      MODE_SYS_TIME: cond = cmp_q;
`ifdef SEGMENT_TRANSITION_GPIO_EN
      MODE_GPIO:     cond = edge_q;
`endif
      default:       cond = 1'b0;
    endcase
    trig = arm && cond;
  end

endmodule

// File: rtl/segment_transition_ctl.sv
// -----------------------------------------------------------------------------
// segment_transition_ctl
//   Read-segment sequencer for one double-buffered sampler. Accepts a
//   segment-switch request, waits for its transition condition, switches the
//   active segment and counts loop repetitions so the sampler can freeze at
//   the end of a finite playback.
//
//   Optional feature macro: SEGMENT_TRANSITION_GPIO_EN (GPIO trigger mode).
//
// Ports:
//   CLK               system clock
//   RST               synchronous active-high reset
//   UPDATE            one-cycle request strobe; samples the REQ_* inputs
//   REQ_SEGMENT       requested read segment
//   REQ_REP           repeat count (all-ones = infinite, switch immediately)
//   TRANSITION_MODE   SYNC_IDX 0x00, SYS_TIME 0x01, GPIO 0x02, EXT 0xF0
//   TRANSITION_VALUE  mode operand (time threshold or GPIO pin index)
//   SYS_TIME          free-running system time
//   GPIO_IN           synchronised trigger pins
//   LOOP_END          sampler index wrap pulse
//   SEGMENT           active read segment
//   STOP              final loop of a finite playback is running
//   SWITCH            one-cycle pulse in the cycle SEGMENT changes
//   PENDING           a request is waiting for its trigger
// -----------------------------------------------------------------------------
module segment_transition_ctl
  import segment_transition_ctl_pkg::*;
#(
  parameter int REP_W  = 16,
  parameter int TIME_W = 64,
  parameter int GPIO_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UPDATE,
  input  logic              REQ_SEGMENT,
  input  logic [REP_W-1:0]  REQ_REP,
  input  logic [7:0]        TRANSITION_MODE,
  input  logic [TIME_W-1:0] TRANSITION_VALUE,
  input  logic [TIME_W-1:0] SYS_TIME,
  input  logic [GPIO_W-1:0] GPIO_IN,
  input  logic              LOOP_END,
  output logic              SEGMENT,
  output logic              STOP,
  output logic              SWITCH,
  output logic              PENDING
);

  localparam logic [REP_W-1:0] REP_INF = REP_W'(rep_infinite(REP_W));

  state_e           state, state_next;
  logic             seg_q, seg_next;
  logic             stop_q, stop_next;
  logic             switch_q, switch_next;
  logic [REP_W-1:0] cnt_q, cnt_next;
  logic             req_seg_q, req_seg_next;
  logic [REP_W-1:0] req_rep_q, req_rep_next;
  logic             load;
  logic             req_ext;
  logic             req_wait;
  logic             trig;

  segment_transition_ctl_trigger_detect #(
    .TIME_W (TIME_W),
    .GPIO_W (GPIO_W)
  ) u_trigger_detect (
    .CLK       (CLK),
    .RST       (RST),
    .req_mode  (TRANSITION_MODE),
    .req_value (TRANSITION_VALUE),
    .load      (load),
    .sys_time  (SYS_TIME),
    .gpio      (GPIO_IN),
    .loop_end  (LOOP_END),
    .arm       (state == ST_WAIT_TRIG),
    .req_ext   (req_ext),
    .req_wait  (req_wait),
    .trig      (trig)
  );

  always_comb begin
    state_next   = state;
    seg_next     = seg_q;
    stop_next    = stop_q;
    switch_next  = 1'b0;
    cnt_next     = cnt_q;
    req_seg_next = req_seg_q;
    req_rep_next = req_rep_q;
    load         = 1'b0;

    // An accepted request takes priority over anything the current state
    // would do this cycle, including a trigger. A request with an unknown
    // mode and finite repeat is not accepted and falls through untouched.
    if (UPDATE && req_ext) begin
      state_next  = ST_EXT;
      seg_next    = REQ_SEGMENT;
      switch_next = 1'b1;
      stop_next   = 1'b0;
    end else if (UPDATE && (REQ_REP == REP_INF)) begin
      state_next  = ST_RUN;
      seg_next    = REQ_SEGMENT;
      switch_next = 1'b1;
      stop_next   = 1'b0;
    end else if (UPDATE && req_wait) begin
      state_next   = ST_WAIT_TRIG;
      req_seg_next = REQ_SEGMENT;
      req_rep_next = REQ_REP;
      stop_next    = 1'b0;
      load         = 1'b1;
    end else begin
      case (state)
        ST_WAIT_TRIG: begin
          if (trig) begin
            state_next  = ST_PLAY_FINITE;
            seg_next    = req_seg_q;
            switch_next = 1'b1;
            cnt_next    = '0;
            stop_next   = (req_rep_q == '0);
          end
        end
        ST_PLAY_FINITE: begin
          if (LOOP_END) begin
            cnt_next = (cnt_q == REP_INF) ? cnt_q : cnt_q + 1'b1;
            if (cnt_next == req_rep_q) stop_next = 1'b1;
          end
        end
        ST_EXT: begin
          if (LOOP_END) begin
            seg_next    = ~seg_q;
            switch_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_RUN;
      seg_q     <= 1'b0;
      stop_q    <= 1'b0;
      switch_q  <= 1'b0;
      cnt_q     <= '0;
      req_seg_q <= 1'b0;
      req_rep_q <= '0;
    end else begin
      state     <= state_next;
      seg_q     <= seg_next;
      stop_q    <= stop_next;
      switch_q  <= switch_next;
      cnt_q     <= cnt_next;
      req_seg_q <= req_seg_next;
      req_rep_q <= req_rep_next;
    end
  end

  assign SEGMENT = seg_q;
  assign STOP    = stop_q;
  assign SWITCH  = switch_q;
  assign PENDING = (state == ST_WAIT_TRIG);

endmodule

// File: tb/tb_segment_transition_ctl.sv
module tb_segment_transition_ctl;
  import segment_transition_ctl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        update = 1'b0;
  logic        req_segment = 1'b0;
  logic [15:0] req_rep = '0;
  logic [7:0]  transition_mode = '0;
  logic [63:0] transition_value = '0;
  logic [63:0] sys_time = '0;
  logic [3:0]  gpio_in = '0;
  logic        loop_end = 1'b0;
  logic        segment;
  logic        stop;
  logic        sw;
  logic        pending;

  // Expected {SEGMENT, STOP, SWITCH, PENDING} after the edge that consumes
  // the stimulus driven alongside the push.
  typedef struct {
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  segment_transition_ctl dut (
    .CLK              (clk),
    .RST              (rst),
    .UPDATE           (update),
    .REQ_SEGMENT      (req_segment),
    .REQ_REP          (req_rep),
    .TRANSITION_MODE  (transition_mode),
    .TRANSITION_VALUE (transition_value),
    .SYS_TIME         (sys_time),
    .GPIO_IN          (gpio_in),
    .LOOP_END         (loop_end),
    .SEGMENT          (segment),
    .STOP             (stop),
    .SWITCH           (sw),
    .PENDING          (pending)
  );

  // Inputs change on the falling edge; outputs are read on the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_idle();
    update   = 1'b0;
    loop_end = 1'b0;
  endtask

  task automatic set_req(input logic s, input logic [15:0] rep,
                         input logic [7:0] mode, input logic [63:0] val);
    update           = 1'b1;
    req_segment      = s;
    req_rep          = rep;
    transition_mode  = mode;
    transition_value = val;
  endtask

  task automatic apply_reset();
    set_idle();
    gpio_in  = '0;
    sys_time = '0;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [3:0] obs;
    for (int i = 0; i < 3; i++) begin
      set_idle();
      rst = (i < 2);
      if (i == 0) set_req(1'b1, 16'hFFFF, MODE_SYNC_IDX, 64'd0);
      sb.push_back('{4'b0000, "reset_state"});
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_immediate();
    exp_t e;
    logic [3:0] obs;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      set_idle();
      case (i)
        0: begin
          set_req(1'b1, 16'hFFFF, MODE_SYNC_IDX, 64'd0);
          sb.push_back('{4'b1010, "imm_switch"});
        end
        2: begin
          loop_end = 1'b1;
          sb.push_back('{4'b1000, "imm_ignores_loop_end"});
        end
        default: sb.push_back('{4'b1000, "imm_hold"});
      endcase
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
  endtask

  task automatic test_sync_idx();
    exp_t e;
    logic [3:0] obs;
    logic [3:0] want;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      set_idle();
      if (i == 0) set_req(1'b1, 16'd2, MODE_SYNC_IDX, 64'd0);
      loop_end = (i == 2) || (i == 4) || (i == 6) || (i == 8);
      // Switch on the first pulse, count 1 on the second, STOP on the third.
      if (i < 2)       want = 4'b0001;
      else if (i == 2) want = 4'b1010;
      else if (i < 6)  want = 4'b1000;
      else             want = 4'b1100;
      sb.push_back('{want, "sync_idx"});
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
  endtask

  task automatic test_sys_time();
    exp_t e;
    logic [3:0] obs;
    logic [3:0] want;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      set_idle();
      sys_time = 64'd989 + 64'(i);
      if (i == 0) set_req(1'b1, 16'd0, MODE_SYS_TIME, 64'd1000);
      // SYS_TIME reaches 1000 in cycle 11; the segment shows in cycle 13.
      if (i < 12)       want = 4'b0001;
      else if (i == 12) want = 4'b1110;
      else              want = 4'b1100;
      sb.push_back('{want, "sys_time"});
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
  endtask

  // Continues from the stopped SYS_TIME playback: the new request clears
  // STOP, and a threshold already in the past fires on the first compare.
  task automatic test_past_time();
    exp_t e;
    logic [3:0] obs;
    sys_time = 64'd5000;
    for (int i = 0; i < 4; i++) begin
      set_idle();
      case (i)
        0: begin
          set_req(1'b0, 16'd1, MODE_SYS_TIME, 64'd100);
          sb.push_back('{4'b1001, "past_pending"});
        end
        1: sb.push_back('{4'b1001, "past_compare"});
        2: sb.push_back('{4'b0010, "past_switch"});
        default: sb.push_back('{4'b0000, "past_hold"});
      endcase
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
  endtask

  task automatic test_gpio();
    exp_t e;
    logic [3:0] obs;
    logic [3:0] want;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      set_idle();
      if (i == 0) set_req(1'b1, 16'd3, MODE_GPIO, 64'd2);
      // A decoy edge on pin 0, then the real edge on pin 2 in cycle 3.
      case (i)
        1:       gpio_in = 4'b0001;
        0, 2:    gpio_in = 4'b0000;
        default: gpio_in = 4'b0100;
      endcase
`ifdef SEGMENT_TRANSITION_GPIO_EN
      if (i < 4)       want = 4'b0001;
      else if (i == 4) want = 4'b1010;
      else             want = 4'b1000;
`else
      want = 4'b0000;
`endif
      sb.push_back('{want, "gpio"});
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
    gpio_in = '0;
  endtask

  task automatic test_ext();
    exp_t e;
    logic [3:0] obs;
    logic [3:0] want;
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      set_idle();
      if (i == 0) set_req(1'b1, 16'hFFFF, MODE_SYNC_IDX, 64'd0);
      if (i == 1) set_req(1'b0, 16'd5, MODE_EXT, 64'd0);
      loop_end = (i == 3) || (i == 5) || (i == 7) || (i == 9);
      case (i)
        0, 3, 7: want = 4'b1010;
        1, 5, 9: want = 4'b0010;
        4, 8:    want = 4'b1000;
        default: want = 4'b0000;
      endcase
      sb.push_back('{want, "ext_toggle"});
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [3:0] obs;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      set_idle();
      case (i)
        0: begin
          set_req(1'b1, 16'd1, MODE_SYNC_IDX, 64'd0);
          sb.push_back('{4'b0001, "b2b_first_pending"});
        end
        1: begin
          // Replacement request collides with the old request's trigger.
          set_req(1'b1, 16'd0, MODE_SYS_TIME, 64'hFFFF_FFFF_FFFF_FFFF);
          loop_end = 1'b1;
          sb.push_back('{4'b0001, "b2b_update_wins"});
        end
        2: begin
          loop_end = 1'b1;
          sb.push_back('{4'b0001, "b2b_old_discarded"});
        end
        3: begin
          set_req(1'b1, 16'd0, MODE_SYNC_IDX, 64'd0);
          sb.push_back('{4'b0001, "b2b_third_pending"});
        end
        4: begin
          loop_end = 1'b1;
          sb.push_back('{4'b1110, "b2b_rep0_switch_stop"});
        end
        5: begin
          set_req(1'b0, 16'd3, 8'h33, 64'd0);
          sb.push_back('{4'b1100, "unknown_mode_dropped"});
        end
        default: begin
          loop_end = 1'b1;
          sb.push_back('{4'b1100, "stop_holds"});
        end
      endcase
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
  endtask

  // Continues from the stopped playback left by test_back_to_back.
  task automatic test_reset_mid();
    exp_t e;
    logic [3:0] obs;
    for (int i = 0; i < 5; i++) begin
      set_idle();
      rst = (i == 0) || (i == 3);
      case (i)
        2: begin
          set_req(1'b1, 16'd0, MODE_SYNC_IDX, 64'd0);
          sb.push_back('{4'b0001, "rst_mid_pending"});
        end
        4: begin
          loop_end = 1'b1;
          sb.push_back('{4'b0000, "rst_mid_pending_lost"});
        end
        default: sb.push_back('{4'b0000, "rst_mid_clear"});
      endcase
      step();
      e = sb.pop_front();
      obs = {segment, stop, sw, pending};
      vectors++;
      if (obs !== e.exp) begin
        miscompares++;
        $display("FAIL %s[%0d]: seg/stop/sw/pend got %b want %b", e.name, i, obs, e.exp);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_sync_idx();
    test_sys_time();
    test_past_time();
    test_gpio();
    test_ext();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/segment_transition_ctl.md
# segment_transition_ctl

Sequences the read-segment selection of one double-buffered sampler (modulation or STM) in the controller datapath. It accepts a segment-switch request latched from the controller register file, waits for the programmed transition condition, switches the active read segment, and counts loop repetitions so the sampler can freeze at the end of a finite playback. One instance serves the modulation sampler and a second instance serves the STM sampler.

## Interface
Parameters:
- REP_W, 16, width of the repeat count; all-ones means infinite.
- TIME_W, 64, width of the system-time bus and of the transition value.
- GPIO_W, 4, number of GPIO trigger inputs.

Ports:
- CLK  in  1  system clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- UPDATE  in  1  one-cycle strobe; samples all request inputs below.
- REQ_SEGMENT  in  1  requested read segment.
- REQ_REP  in  REP_W  repeat count for the requested segment.
- TRANSITION_MODE  in  8  transition mode: SYNC_IDX=0x00, SYS_TIME=0x01, GPIO=0x02, EXT=0xF0.
- TRANSITION_VALUE  in  TIME_W  mode operand.
- SYS_TIME  in  TIME_W  free-running system time.
- GPIO_IN  in  GPIO_W  external trigger pins, already synchronised.
- LOOP_END  in  1  pulse from the sampler when its index wraps from CYCLE-1 to 0.
- SEGMENT  out  1  active read segment.
- STOP  out  1  high while the final loop of a finite playback runs; the sampler holds at index CYCLE-1.
- SWITCH  out  1  one-cycle pulse in the cycle SEGMENT changes.
- PENDING  out  1  a request is waiting for its trigger.

## Operation
- States: RUN, WAIT_TRIG, PLAY_FINITE, EXT.
- Reset values: state RUN, SEGMENT=0, STOP=0, SWITCH=0, PENDING=0, loop counter 0.
- On UPDATE, in any state:
  - If REQ_REP is all-ones, the switch is immediate. SEGMENT takes REQ_SEGMENT next cycle, STOP=0, and the state becomes RUN. The mode is ignored unless it is EXT.
  - If the mode is EXT, SEGMENT takes REQ_SEGMENT, the state becomes EXT, and SEGMENT toggles on every LOOP_END thereafter. STOP stays 0.
  - Otherwise the request is latched, the state becomes WAIT_TRIG, and PENDING=1.
- WAIT_TRIG trigger conditions:
  - SYNC_IDX: a LOOP_END pulse.
  - SYS_TIME: registered compare SYS_TIME >= TRANSITION_VALUE.
  - GPIO: rising edge of GPIO_IN[TRANSITION_VALUE[1:0]].
- On the trigger: SEGMENT updates, SWITCH pulses, PENDING=0, the loop counter clears, and the state becomes PLAY_FINITE.
- PLAY_FINITE:
  - The loop counter increments on each LOOP_END.
  - STOP asserts once the counter equals the latched REP. With REP=0, STOP asserts together with the switch.
  - STOP and the state hold until the next UPDATE.
- A request with an unknown mode is dropped: state, SEGMENT and STOP are unchanged.
- A request with SYS_TIME mode whose value is already in the past triggers on the first compare (next cycle).

## Timing
- Immediate and EXT entry: SEGMENT changes 1 cycle after UPDATE.
- SYNC_IDX and GPIO: SEGMENT and SWITCH register 1 cycle after the LOOP_END or edge cycle. The GPIO edge detector adds 1 register stage.
- SYS_TIME: the compare is registered, so SEGMENT changes 2 cycles after the first cycle in which SYS_TIME >= value.
- SWITCH is high for exactly 1 cycle per change, including each EXT toggle.
- UPDATE in the same cycle as a trigger: UPDATE wins. The old pending request is discarded and no switch occurs that cycle.
- UPDATE while WAIT_TRIG: the new request replaces the pending one.
- The loop counter saturates at all-ones and never wraps.
- RST mid-operation: all state returns to reset values on the next edge, and any pending request is lost.

## Configuration
- SEGMENT_TRANSITION_GPIO_EN:
  - Defined: GPIO mode, the GPIO_IN edge detector and the pin select are built.
  - Undefined: GPIO_IN is ignored and mode 0x02 is treated as an unknown mode, so the request is dropped.

## Structure
- Shared package holds:
  - the transition-mode enum (SYNC_IDX, SYS_TIME, GPIO, EXT);
  - the state enum;
  - the constant for the infinite-repeat value (all-ones of REP_W).
- Sub-module trigger_detect holds the mode decode, the registered SYS_TIME compare and the GPIO edge detector, and outputs a single-cycle TRIG.
- The top level holds the FSM, the loop counter and the output registers.

## Test plan
- Reset, then UPDATE with seg=1, REP=0xFFFF, mode SYNC_IDX -> SEGMENT=1 one cycle later, SWITCH pulses once, STOP=0, PENDING never rises.
- UPDATE with seg=1, REP=2, mode SYNC_IDX, then three LOOP_END pulses -> switch on the first pulse; STOP rises the cycle after the third pulse (counter=2) and stays high.
- UPDATE with mode SYS_TIME, value=1000, SYS_TIME ramping from 990 -> PENDING until SYS_TIME=1000; SEGMENT changes 2 cycles later; REP=0 -> STOP rises with the switch.
- With the GPIO macro defined, mode GPIO, value=2, rising edge on GPIO_IN[2] -> switch 2 cycles after the edge. With the macro undefined, the same stimulus -> no change, PENDING=0.
- Mode EXT, seg=0, then 4 LOOP_END pulses -> SEGMENT sequence 0,1,0,1,0 with one SWITCH pulse per toggle; a second UPDATE in the same cycle as a LOOP_END in WAIT_TRIG -> the new request is retained and there is no switch.
- RST asserted in PLAY_FINITE with STOP=1 -> SEGMENT=0, STOP=0, PENDING=0 the next cycle.
